path_decoder_2way_buffered: RTL and testbench
=============================================

// Module: path_decoder_2way_buffered
// PURPOSE
//  Buffered successor of the forward-north / forward-south decode stage of the 2-D spike mesh.
//  - Queues incoming packets in a FIFO.
//  - Decodes the signed dy hop field of the packet at the FIFO head.
//  - Forwards the packet to the next hop (port a), with dy += ADD, or ejects it locally (port b), with dy stripped.
//  - Honours per-output full back-pressure and registers both outputs.
//  - Instantiated once per direction: ADD=-1 for north, ADD=+1 for south.
// PARAMETERS
//  DATA_WIDTH   23  packet width
//  DY_MSB       20  dy field MSB (signed field)
//  DY_LSB       12  dy field LSB; DY_W = DY_MSB-DY_LSB+1
//  ADD          1   signed step added to dy on forward (+1 south, -1 north)
//  FIFO_DEPTH   4   input queue entries; power of 2, >=2
//  STATS_WIDTH  16  width of the optional statistics counters
// PORTS
//  clk       in   1              clock, all state on rising edge
//  rst       in   1              asynchronous, active-high reset
//  din       in   DATA_WIDTH     packet from upstream
//  wen       in   1              din valid; accepted only when full==0
//  full      out  1              queue holds FIFO_DEPTH entries
//  overflow  out  1              sticky; wen seen while full==1
//  dout_a    out  DATA_WIDTH     forwarded packet, dy replaced by dy+ADD
//  wen_a     out  1              one-cycle strobe per dout_a packet
//  full_a    in   1              next-hop cannot accept
//  dout_b    out  DATA_WIDTH-DY_W  local packet: {din[DATA_WIDTH-1:DY_MSB+1], din[DY_LSB-1:0]}
//  wen_b     out  1              one-cycle strobe per dout_b packet
//  full_b    in   1              local sink cannot accept
// BEHAVIOUR
//  - Reset (async, any cycle, including mid-transfer):
//    - FIFO emptied, pointers zeroed.
//    - full=0, overflow=0, wen_a=wen_b=0, dout_a=dout_b=0, stats=0.
//    - In-flight packets are discarded.
//  - Push: on an edge with wen=1 and full=0, din is written at the tail.
//    - full is the registered count==FIFO_DEPTH.
//    - A write while full is dropped and sets overflow, even if a pop occurs in that same cycle.
//  - Decode: from the head entry.
//    - dy = head[DY_MSB:DY_LSB], signed.
//    - Target is b if dy==0, otherwise a.
//  - Pop: on an edge with FIFO non-empty and the target's full_x=0:
//    - Head is popped.
//    - dout_x/wen_x are registered: wen_x=1 for exactly the following cycle.
//    - The other port's wen is 0 in that cycle.
//    - dout_x holds its last value when idle.
//  - Blocking: if the target is full, the head stalls.
//    - Strict FIFO order; no bypass to the other port (head-of-line blocking is intended).
//    - Sustained rate is 1 packet/cycle when the target is free.
//  - Simultaneous push and pop: count is unchanged. Push into an empty FIFO is not poppable until the next edge.
//  - Latency: din accepted at edge t -> wen_x high in the cycle after edge t+1.
//  - Arithmetic: dy+ADD is computed in DY_W bits, modulo 2^DY_W (wraps, no saturation). Non-dy bits pass unchanged.
//  - full_a/full_b are sampled only on the pop edge. A change while not popping has no effect.
// CONFIGURATION
//  PATH_DECODER_STATS_EN defined:
//    - Adds ports cnt_a, cnt_b (out, STATS_WIDTH).
//    - Each counts completed pops to a / b.
//    - Wraps at 2^STATS_WIDTH; cleared by rst.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING  (defaults, ADD=-1 unless stated)
//  - Local eject: din=23'h0000AB, wen 1 cycle
//    -> wen_b=1 two edges later, dout_b=14'h0AB, wen_a stays 0.
//  - Forward: din=23'h0030AB (dy=3)
//    -> wen_a strobe, dout_a=23'h0020AB.
//    - Same packet with ADD=+1 -> dout_a=23'h0040AB.
//  - Wrap: ADD=+1, din=23'h1FF0AB (dy=-1)
//    -> dout_a=23'h0000AB via port a (decision uses the pre-add dy).
//  - Back-pressure: full_a=1, push 5 dy=1 packets
//    -> full=1 after 4, 5th dropped, overflow=1.
//    - Release full_a: 4 wen_a strobes on consecutive cycles, in order.
//  - HOL order: queue {dy=1, dy=0} with full_a=1, full_b=0
//    -> no wen_b until full_a drops. Then wen_a, then wen_b next cycle.
//  - Reset mid-stream: assert rst with 3 queued packets
//    -> outputs 0 immediately, no strobes after release.
//    - With stats enabled, cnt_a=cnt_b=0.

Source files
------------

// File: rtl/path_decoder_2way_buffered.sv
// Buffered forward/eject decode stage: FIFO-queued packets, signed dy decode at the head,
// forward on port a with dy+ADD or eject on port b with dy stripped.
// Optional statistics counters cnt_a/cnt_b enabled by defining PATH_DECODER_STATS_EN.
module path_decoder_2way_buffered #(
  parameter int DATA_WIDTH  = 23,
  parameter int DY_MSB      = 20,
  parameter int DY_LSB      = 12,
  parameter int ADD         = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int STATS_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DATA_WIDTH-1:0]                 din,
  input  logic                                  wen,
  output logic                                  full,
  output logic                                  overflow,
  output logic [DATA_WIDTH-1:0]                 dout_a,
  output logic                                  wen_a,
  input  logic                                  full_a,
  output logic [DATA_WIDTH-(DY_MSB-DY_LSB+1)-1:0] dout_b,
  output logic                                  wen_b,
  input  logic                                  full_b
`ifdef PATH_DECODER_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]                cnt_a,
  output logic [STATS_WIDTH-1:0]                cnt_b
`endif
);
  localparam int DY_W = DY_MSB - DY_LSB + 1;
  localparam int BW   = DATA_WIDTH - DY_W;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [DY_W-1:0] ADD_W   = DY_W'(ADD);
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d, overflow_q, overflow_d;
  logic                  wen_a_q, wen_a_d, wen_b_q, wen_b_d;
  logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d;
  logic [BW-1:0]         dout_b_q, dout_b_d;

  logic [DATA_WIDTH-1:0] head, fwd;
  logic [DY_W-1:0]       dy;
  logic                  to_b, push, pop;

  always_comb begin
    head = mem_q[rd_ptr_q];
    dy   = head[DY_MSB:DY_LSB];
    to_b = (dy == '0);
    push = wen & ~full_q;
    // Head-of-line: only the head's own target gates the pop, never the other port.
    pop  = (count_q != '0) & (to_b ? ~full_b : ~full_a);

    fwd                = head;
    fwd[DY_MSB:DY_LSB] = dy + ADD_W;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = din;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    full_d     = (count_d == DEPTH_C);
    overflow_d = overflow_q | (wen & full_q);

    wen_a_d  = pop & ~to_b;
    wen_b_d  = pop & to_b;
    dout_a_d = (pop & ~to_b) ? fwd : dout_a_q;
    dout_b_d = (pop & to_b) ? {head[DATA_WIDTH-1:DY_MSB+1], head[DY_LSB-1:0]} : dout_b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      wen_a_q    <= 1'b0;
      wen_b_q    <= 1'b0;
      dout_a_q   <= '0;
      dout_b_q   <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      wen_a_q    <= wen_a_d;
      wen_b_q    <= wen_b_d;
      dout_a_q   <= dout_a_d;
      dout_b_q   <= dout_b_d;
    end
  end

  assign full     = full_q;
  assign overflow = overflow_q;
  assign wen_a    = wen_a_q;
  assign wen_b    = wen_b_q;
  assign dout_a   = dout_a_q;
  assign dout_b   = dout_b_q;

`ifdef PATH_DECODER_STATS_EN
  logic [STATS_WIDTH-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  always_comb begin
    cnt_a_d = cnt_a_q + STATS_WIDTH'(pop & ~to_b);
    cnt_b_d = cnt_b_q + STATS_WIDTH'(pop & to_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_path_decoder_2way_buffered.sv
// Scoreboard bench: a north (ADD=-1) and south (ADD=+1) instance share stimulus;
// expected packets are queued per instance on push and popped on every output strobe.
module tb_path_decoder_2way_buffered;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [22:0] din = '0;
  logic        wen = 1'b0, full_a = 1'b0, full_b = 1'b0;

  logic        full_n, ovf_n, wen_a_n, wen_b_n, full_s, ovf_s, wen_a_s, wen_b_s;
  logic [22:0] dout_a_n, dout_a_s;
  logic [13:0] dout_b_n, dout_b_s;
`ifdef PATH_DECODER_STATS_EN
  logic [15:0] cnt_a_n, cnt_b_n, cnt_a_s, cnt_b_s;
`endif

  int n_tests = 0, n_fail = 0;
  logic [23:0] q_n[$], q_s[$];  // {is_b, payload}

  always #5 clk = ~clk;

  path_decoder_2way_buffered #(.ADD(-1)) dut_n (
    .clk(clk), .rst(rst), .din(din), .wen(wen), .full(full_n), .overflow(ovf_n),
    .dout_a(dout_a_n), .wen_a(wen_a_n), .full_a(full_a),
    .dout_b(dout_b_n), .wen_b(wen_b_n), .full_b(full_b)
`ifdef PATH_DECODER_STATS_EN
    , .cnt_a(cnt_a_n), .cnt_b(cnt_b_n)
`endif
  );

  path_decoder_2way_buffered #(.ADD(1)) dut_s (
    .clk(clk), .rst(rst), .din(din), .wen(wen), .full(full_s), .overflow(ovf_s),
    .dout_a(dout_a_s), .wen_a(wen_a_s), .full_a(full_a),
    .dout_b(dout_b_s), .wen_b(wen_b_s), .full_b(full_b)
`ifdef PATH_DECODER_STATS_EN
    , .cnt_a(cnt_a_s), .cnt_b(cnt_b_s)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] model(input logic [22:0] d, input logic [8:0] add);
    logic [22:0] r;
    r = d;
    if (d[20:12] == 9'd0) return {1'b1, 9'd0, d[22:21], d[11:0]};
    r[20:12] = d[20:12] + add;
    return {1'b0, r};
  endfunction

  task automatic mon(input int d, input logic wa, input logic wb,
                     input logic [22:0] da, input logic [13:0] db);
    logic [23:0] e;
    if (!(wa || wb)) return;
    chk(d == 0 ? "n_one_hot" : "s_one_hot", {30'd0, wa, wb}, {30'd0, ~wb, wb});
    if ((d == 0 && q_n.size() == 0) || (d == 1 && q_s.size() == 0)) begin
      chk(d == 0 ? "n_unexpected_strobe" : "s_unexpected_strobe", 32'd1, 32'd0);
      return;
    end
    e = (d == 0) ? q_n.pop_front() : q_s.pop_front();
    chk(d == 0 ? "n_port" : "s_port", {31'd0, wb}, {31'd0, e[23]});
    if (e[23]) chk(d == 0 ? "n_dout_b" : "s_dout_b", {18'd0, db}, {18'd0, e[13:0]});
    else       chk(d == 0 ? "n_dout_a" : "s_dout_a", {9'd0, da}, {9'd0, e[22:0]});
  endtask

  always @(negedge clk) if (!rst) begin
    mon(0, wen_a_n, wen_b_n, dout_a_n, dout_b_n);
    mon(1, wen_a_s, wen_b_s, dout_a_s, dout_b_s);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [22:0] d, input logic acc);
    din = d;
    wen = 1'b1;
    if (acc) begin
      q_n.push_back(model(d, 9'h1FF));
      q_s.push_back(model(d, 9'h001));
    end
    tick();
    wen = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((q_n.size() != 0 || q_s.size() != 0) && k < 50) begin
      tick();
      k++;
    end
    @(negedge clk);
    chk(tag, q_n.size() + q_s.size(), 0);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_outs", {wen_a_n, wen_b_n, full_n, ovf_n, wen_a_s, wen_b_s, full_s, ovf_s}, 0);
    chk("rst_dout", {dout_a_n[15:0], dout_b_n[13:0]}, 0);
    rst = 1'b0;
    tick();

    // local eject with exact latency
    push(23'h0000AB, 1'b1);
    @(negedge clk); chk("eject_not_early", {31'd0, wen_b_n}, 0);
    @(negedge clk);
    chk("eject_wen_b", {31'd0, wen_b_n}, 1);
    chk("eject_wen_a", {31'd0, wen_a_n}, 0);
    chk("eject_dout_b", {18'd0, dout_b_n}, 32'h0AB);
    drain("eject_drain");

    // forward and wrap (dy=3, dy=-1)
    push(23'h0030AB, 1'b1);
    push(23'h1FF0AB, 1'b1);
    drain("fwd_drain");

    // back-pressure and overflow
    full_a = 1'b1;
    for (int i = 0; i < 4; i++) push(23'h001000 | 23'(i), 1'b1);
    @(negedge clk);
    chk("bp_full", {30'd0, full_n, full_s}, 32'd3);
    chk("bp_ovf_clear", {30'd0, ovf_n, ovf_s}, 0);
    push(23'h001077, 1'b0);
    @(negedge clk);
    chk("bp_ovf", {30'd0, ovf_n, ovf_s}, 32'd3);
    #1 full_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_burst", {31'd0, wen_a_n}, 1);
    end
    @(negedge clk); chk("bp_burst_end", {31'd0, wen_a_n}, 0);
    drain("bp_drain");

    // head-of-line: dy=1 blocks a dy=0 behind it
    full_a = 1'b1;
    push(23'h0010C1, 1'b1);
    push(23'h0000C2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hol_no_b", {30'd0, wen_b_n, wen_b_s}, 0);
    end
    #1 full_a = 1'b0;
    @(negedge clk); chk("hol_a_first", {30'd0, wen_a_n, wen_b_n}, 32'd2);
    @(negedge clk); chk("hol_b_next", {30'd0, wen_a_n, wen_b_n}, 32'd1);
    drain("hol_drain");

    // sustained random stream, both ports free
    for (int i = 0; i < 16; i++) begin
      logic [22:0] r;
      r = 23'($urandom);
      case (i % 4)
        0: r[20:12] = 9'd0;
        1: r[20:12] = 9'h1FF;
        2: r[20:12] = 9'h0FF;
        default: ;
      endcase
      push(r, 1'b1);
    end
    drain("rand_drain");

    // reset mid-stream with queued packets
    full_a = 1'b1;
    for (int i = 0; i < 3; i++) push(23'h002010 | 23'(i), 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_outs", {wen_a_n, wen_b_n, full_n, ovf_n, wen_a_s, wen_b_s, full_s, ovf_s}, 0);
    chk("midrst_dout_a", {9'd0, dout_a_n}, 0);
    chk("midrst_dout_b", {18'd0, dout_b_s}, 0);
`ifdef PATH_DECODER_STATS_EN
    chk("midrst_cnt", {cnt_a_n[7:0], cnt_b_n[7:0], cnt_a_s[7:0], cnt_b_s[7:0]}, 0);
`endif
    q_n.delete();
    q_s.delete();
    tick();
    rst = 1'b0;
    full_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_silent", {28'd0, wen_a_n, wen_b_n, wen_a_s, wen_b_s}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
